// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the period-exact test waveform generator.
package wave_gen_pkg;
    localparam int DATA_WIDTH = 12;
    localparam int AMP_WIDTH  = DATA_WIDTH - 1;
    localparam int DIVD_WIDTH = DATA_WIDTH + 1;

    localparam logic WAVE_SQUARE = 1'b0;
    localparam logic WAVE_TRI    = 1'b1;
    localparam logic [DATA_WIDTH-1:0] MIN_PERIOD = 4;

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_e;

    // quo/rem are the per-sample triangle slope (4A)/P split into integer and fractional parts
    typedef struct packed {
        logic [DATA_WIDTH-1:0] period;
        logic [AMP_WIDTH-1:0]  amp;
        logic                  wave;
        logic [DIVD_WIDTH-1:0] quo;
        logic [DATA_WIDTH-1:0] rem;
    } cfg_t;

    function automatic logic [DATA_WIDTH-1:0] clamp_period(input logic [DATA_WIDTH-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction
endpackage

// File: rtl/period_wave_gen_if.sv
// Configuration handshake, run control and sample output of the waveform generator.
interface period_wave_gen_if;
    import wave_gen_pkg::*;

    logic                  enable;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATA_WIDTH-1:0] cfg_period;
    logic [AMP_WIDTH-1:0]  cfg_amp;
    logic                  cfg_wave;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  sync;
    logic                  running;

    modport master (
        output enable, cfg_valid, cfg_period, cfg_amp, cfg_wave,
        input  cfg_ready, data_out, sync, running
    );

    modport slave (
        input  enable, cfg_valid, cfg_period, cfg_amp, cfg_wave,
        output cfg_ready, data_out, sync, running
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses DVD_W+1 cycles after start.
// start is ignored while busy; rst aborts a divide in progress.
module seq_divider #(
    parameter int DVD_W = 13,
    parameter int DVS_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quo_o,
    output logic [DVS_W-1:0] rem_o
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, dvs_q;
    logic [DVD_W-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [DVS_W:0]   trial, diff;
    logic             fits;

    // remainder stays below the divisor, so a clear borrow bit means the trial subtraction fits
    always_comb begin
        trial = {rem_q, quo_q[DVD_W-1]};
        diff  = trial - {1'b0, dvs_q};
        fits  = !diff[DVS_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(DVD_W);
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dvs_q  <= divisor_i;
            end else if (busy_q) begin
                rem_q <= fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
                quo_q <= {quo_q[DVD_W-2:0], fits};
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
endmodule

// File: rtl/period_wave_gen.sv
// Square/triangle test waveform with an exact period in samples; one registered sample per clock.
// cfg_ready stays low from an accepted word until it becomes the active config.
module period_wave_gen
    import wave_gen_pkg::*;
(
    input  logic             adc_clk,
    input  logic             rst,
    period_wave_gen_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] PH_ONE = 1;

    state_e                       state_q;
    cfg_t                         act_q, pend_q, div_cfg, scfg;
    logic                         act_vld_q, pend_vld_q, pend_done_q;
    logic [DATA_WIDTH-1:0]        ph_q, sph, half, amp_pos;
    logic [DATA_WIDTH:0]          err_q, err_sum, smp_err;
    logic [DATA_WIDTH-1:0]        data_q, smp_data;
    logic                         sync_q, transfer, wrap, carry;
    logic signed [DATA_WIDTH+1:0] acc, amp_lim, step;
    logic                         div_busy, div_done;
    logic [DIVD_WIDTH-1:0]        div_quo;
    logic [DATA_WIDTH-1:0]        div_rem;

    assign transfer      = bus.cfg_valid && bus.cfg_ready;
    assign bus.cfg_ready = !pend_vld_q && !div_busy;
    assign bus.data_out  = data_q;
    assign bus.sync      = sync_q;
    assign bus.running   = (state_q == RUN);

    seq_divider #(.DVD_W(DIVD_WIDTH), .DVS_W(DATA_WIDTH)) u_div (
        .clk        (adc_clk),
        .rst        (rst),
        .start_i    (transfer),
        .dividend_i ({bus.cfg_amp, 2'b00}),
        .divisor_i  (clamp_period(bus.cfg_period)),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // Select the config and phase of the next sample; a finished pending word takes over only at a wrap.
    always_comb begin
        div_cfg     = pend_q;
        div_cfg.quo = div_quo;
        div_cfg.rem = div_rem;
        wrap        = (ph_q == act_q.period - PH_ONE);
        scfg        = act_q;
        sph         = '0;
        if (state_q == DIV)                     scfg = div_cfg;
        else if (state_q == RUN && !wrap)       sph  = ph_q + PH_ONE;
        else if (state_q == RUN && pend_done_q) scfg = pend_q;
    end

    always_comb begin
        half     = scfg.period >> 1;
        amp_pos  = {1'b0, scfg.amp};
        amp_lim  = $signed({3'b000, scfg.amp});
        err_sum  = err_q + {1'b0, scfg.rem};
        carry    = (err_sum >= {1'b0, scfg.period});
        step     = $signed({1'b0, scfg.quo}) + $signed({{(DATA_WIDTH+1){1'b0}}, carry});
        acc      = $signed({{2{data_q[DATA_WIDTH-1]}}, data_q});
        acc      = (sph <= half) ? acc + step : acc - step;
        if (acc > amp_lim)       acc = amp_lim;
        else if (acc < -amp_lim) acc = -amp_lim;
        smp_err  = carry ? err_sum - {1'b0, scfg.period} : err_sum;
        smp_data = acc[DATA_WIDTH-1:0];
        if (sph == '0) begin
            smp_err  = '0;
            smp_data = (scfg.wave == WAVE_TRI) ? -amp_pos : amp_pos;
        end else if (scfg.wave == WAVE_SQUARE) begin
            smp_data = (sph < half) ? amp_pos : -amp_pos;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            act_vld_q   <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_done_q <= 1'b0;
            ph_q        <= '0;
            err_q       <= '0;
            data_q      <= '0;
            sync_q      <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            if (transfer) begin
                pend_q.period <= clamp_period(bus.cfg_period);
                pend_q.amp    <= bus.cfg_amp;
                pend_q.wave   <= bus.cfg_wave;
                pend_vld_q    <= 1'b1;
            end
            if (div_done) begin
                pend_q.quo  <= div_quo;
                pend_q.rem  <= div_rem;
                pend_done_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    data_q <= '0;
                    if (transfer) begin
                        state_q <= DIV;
                    end else if (pend_done_q) begin
                        // a divide that finished after enable dropped: nothing is playing, adopt it now
                        act_q       <= pend_q;
                        act_vld_q   <= 1'b1;
                        pend_vld_q  <= 1'b0;
                        pend_done_q <= 1'b0;
                    end else if (bus.enable && act_vld_q) begin
                        state_q <= RUN;
                        ph_q    <= sph;
                        err_q   <= smp_err;
                        data_q  <= smp_data;
                        sync_q  <= 1'b1;
                    end
                end
                DIV: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;
                    end else if (div_done) begin
                        state_q     <= RUN;
                        act_q       <= div_cfg;
                        act_vld_q   <= 1'b1;
                        pend_vld_q  <= 1'b0;
                        pend_done_q <= 1'b0;
                        ph_q        <= sph;
                        err_q       <= smp_err;
                        data_q      <= smp_data;
                        sync_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;
                        data_q  <= '0;
                    end else begin
                        ph_q   <= sph;
                        err_q  <= smp_err;
                        data_q <= smp_data;
                        sync_q <= (sph == '0);
                        if (wrap && pend_done_q) begin
                            act_q       <= pend_q;
                            pend_vld_q  <= 1'b0;
                            pend_done_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/period_wave_gen.md
# period_wave_gen

Synthesizes a signed square or triangle test waveform with a programmable period in samples and a programmable amplitude. It is the transmit-side counterpart of the zero-crossing frequency measurement path: it produces a signal whose period is known exactly, for loopback into the measurement path. The per-sample triangle slope is produced by a sequential divider at configuration time. Sample generation uses Bresenham-style error accumulation, so there is no multiplier or divider in the sample path.

## Interface
- DATA_WIDTH, 12, sample width of `data_out` and width of the period/amplitude configuration.
- adc_clk  in  1  sample clock; one output sample per cycle.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- cfg_valid  in  1  configuration handshake valid.
- cfg_ready  out  1  configuration handshake ready.
- cfg_period  in  DATA_WIDTH  period in samples, unsigned.
- cfg_amp  in  DATA_WIDTH-1  peak amplitude A, unsigned.
- cfg_wave  in  1  waveform select: 0 = square, 1 = triangle.
- data_out  out  DATA_WIDTH  signed sample, registered.
- sync  out  1  one-cycle pulse in the cycle `data_out` carries phase 0.
- running  out  1  high while in RUN.

## Operation
- FSM states: IDLE, DIV, RUN.
- Transfer rule: a transfer occurs when `cfg_valid && cfg_ready`. The accepted word is latched into a pending register.
- Period clamp: `cfg_period < 4` is clamped to 4.
- `cfg_ready` is high when no pending word is held and the divider is idle.
- Divide: the accepted word starts the divider computing q = (4·A) / P and r = (4·A) % P. The 4·A term is DATA_WIDTH+1 bits wide.
- IDLE:
  - `data_out` = 0.
  - Go to DIV on a transfer.
  - Go to RUN when `enable` is high and an active config exists.
- DIV (entered from IDLE only):
  - Wait for divider done.
  - Pending becomes active.
  - Go to RUN if `enable` is high, else IDLE.
- RUN:
  - Phase counter ph counts 0…P−1 and wraps.
  - A transfer in RUN divides in the background. The pending config becomes active at the first wrap (ph → 0) after divider done, and the old config runs to the end of its period.
- Square: `data_out` = +A for ph < P>>1, else −A.
- Triangle:
  - At ph = 0, `data_out` = −A and err = 0.
  - Otherwise err += r; if err ≥ P, carry = 1 and err −= P.
  - For 1 ≤ ph ≤ P>>1, value += q+carry; else value −= q+carry.
  - The result is clamped to [−A, +A].
  - Reset at every wrap means there is no drift across periods.
- `enable` low in RUN or DIV: IDLE next cycle and `data_out` = 0. The active config is retained, and a divide in progress still completes into pending.
- Re-enable: restarts at ph = 0 with the active config, with no new divide.

## Timing
- Reset values:
  - `data_out` = 0, `sync` = 0, `running` = 0, `cfg_ready` = 1.
  - FSM in IDLE; no active or pending config.
  - The divider is aborted.
- Divider latency: DATA_WIDTH+1 cycles after the transfer cycle T; done at T+DATA_WIDTH+2.
- From IDLE with `enable` high: first `sync` and first sample at T+DATA_WIDTH+3.
- `cfg_ready` falls in cycle T+1. It rises again in the cycle after the pending config becomes active.
- `sync` is asserted exactly once per period, co-timed with the ph = 0 sample.
- Reset mid-divide or mid-period: reset values apply on the next edge.

## Structure
- Package `wave_gen_pkg`: the waveform encoding constants (WAVE_SQUARE, WAVE_TRI), the state enum, and MIN_PERIOD = 4.
- Sub-module `seq_divider`: restoring unsigned divider, one quotient bit per cycle, with start/done handshake and synchronous abort on `rst`.
- The top level holds the FSM, config registers, phase counter and sample generator.

## Test plan
- Square, P=100, A=1000: +1000 for 50 cycles, then −1000 for 50; `sync` every 100 cycles.
- Triangle, P=8, A=4: repeating sequence −4, −2, 0, 2, 4, 2, 0, −2; `sync` on each −4 sample.
- Triangle, P=7, A=100: `data_out` always within ±100; every ph = 0 sample is −100 across 50 periods (no drift).
- Reconfigure in RUN, square P=100 → 60 at ph=10:
  - The old period completes (90 more cycles).
  - Next `sync` interval is 60.
  - `cfg_ready` is low in between.
- `cfg_period`=2: behaves as P=4 (square +A, +A, −A, −A).
- `rst` asserted mid-divide: next cycle all outputs are at reset values; the previous config is not used when `enable` is next raised.
